cpuport_bus_master: RTL and testbench

- Initiator-side sequencer for the simple peripheral bus used by the CPU port register block: cs, addr, bus_write, write data, registered read data, global ready.
- Accepts single commands (READ, WRITE, read-modify-write SET/CLR) on a valid/ready interface.
- Runs the bus cycles, honouring ready stalls and registered read latency, and returns one response per command.
- Sits between the CPU core's I/O request path and small register peripherals such as the $00/$01 port.

---
 rtl/cpuport_bus_master_pkg.sv | 27 ++
 rtl/cpuport_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_cpuport_bus_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpuport_bus_master_pkg.sv
// Shared types for the CPU-port bus master: command opcodes, FSM states,
// the default stall limit and the read-modify-write combine.
package cpuport_bus_master_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_RMW_SET = 2'd2,
    OP_RMW_CLR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic [7:0] rmw_combine(input op_e op, input logic [7:0] old_val,
                                             input logic [7:0] mask);
    return (op == OP_RMW_CLR) ? (old_val & ~mask) : (old_val | mask);
  endfunction

endpackage

// File: rtl/cpuport_bus_master.sv
// Single-command sequencer for the peripheral bus behind the CPU port.
// Optional stall watchdog enabled by defining CPUPORT_MASTER_TIMEOUT_EN.
module cpuport_bus_master
  import cpuport_bus_master_pkg::*;
#(
  parameter int ADDR_W       = 1,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              bus_cs,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_write,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ready
);

  state_e r_state, w_state_nxt;
  op_e    r_op, w_op_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [7:0] r_result, w_result_nxt;
  logic       r_err, w_err_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;

  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0]        r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_bus_cs, w_bus_cs_nxt;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_nxt;
  logic              r_bus_write, w_bus_write_nxt;
  logic [7:0]        r_bus_wdata, w_bus_wdata_nxt;

  logic w_abort;

`ifdef CPUPORT_MASTER_TIMEOUT_EN
  logic [7:0] r_stall;
  logic       w_stalling;

  assign w_stalling = ((r_state == RD_ADDR) || (r_state == WR)) && !bus_ready;
  assign w_abort    = w_stalling && (r_stall == 8'(TIMEOUT - 1));

  // Counts only consecutive stall cycles within one state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((w_state_nxt != r_state) || !w_stalling) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_abort          = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  // NOTE: reset is synchronous here, so it is tested inside the clocked branch
  // and takes priority over every other update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_READ;
      r_data      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_bus_cs    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_write <= 1'b0;
      r_bus_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_data      <= w_data_nxt;
      r_result    <= w_result_nxt;
      r_err       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_bus_cs    <= w_bus_cs_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_write <= w_bus_write_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (cmd_valid) w_state_nxt = (op_e'(cmd_op) == OP_WRITE) ? WR : RD_ADDR;
      RD_ADDR: if (w_abort) w_state_nxt = RESP;
               else if (bus_ready) w_state_nxt = RD_WAIT;
      RD_WAIT: if (r_cnt == 2'd0) w_state_nxt = (r_op == OP_READ) ? RESP : WR;
      WR:      if (w_abort || bus_ready) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_op_nxt        = r_op;
    w_data_nxt      = r_data;
    w_result_nxt    = r_result;
    w_err_nxt       = r_err;
    w_cnt_nxt       = r_cnt;
    w_cmd_ready_nxt = (w_state_nxt == IDLE);
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_bus_cs_nxt    = r_bus_cs;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_write_nxt = r_bus_write;
    w_bus_wdata_nxt = r_bus_wdata;
    unique case (r_state)
      IDLE: if (cmd_valid) begin
        w_op_nxt        = op_e'(cmd_op);
        w_data_nxt      = cmd_data;
        w_result_nxt    = cmd_data;
        w_err_nxt       = 1'b0;
        w_bus_cs_nxt    = 1'b1;
        w_bus_addr_nxt  = cmd_addr;
        w_bus_write_nxt = (op_e'(cmd_op) == OP_WRITE);
        w_bus_wdata_nxt = cmd_data;
      end
      RD_ADDR: if (w_abort) begin
        w_bus_cs_nxt = 1'b0;
        w_result_nxt = '0;
        w_err_nxt    = 1'b1;
      end else if (bus_ready) begin
        w_bus_cs_nxt = 1'b0;
        w_cnt_nxt    = 2'(READ_LATENCY - 1);
      end
      // Read data arrives on a fixed schedule, so bus_ready is ignored here.
      RD_WAIT: if (r_cnt == 2'd0) begin
        w_result_nxt = bus_rdata;
        if (r_op != OP_READ) begin
          w_bus_cs_nxt    = 1'b1;
          w_bus_write_nxt = 1'b1;
          w_bus_wdata_nxt = rmw_combine(r_op, bus_rdata, r_data);
        end
      end else begin
        w_cnt_nxt = r_cnt - 2'd1;
      end
      WR: if (w_abort || bus_ready) begin
        w_bus_cs_nxt    = 1'b0;
        w_bus_write_nxt = 1'b0;
        if (w_abort) begin
          w_result_nxt = '0;
          w_err_nxt    = 1'b1;
        end
      end
      RESP: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = r_result;
        w_rsp_err_nxt   = r_err;
      end
      default: ;
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign bus_cs    = r_bus_cs;
  assign bus_addr  = r_bus_addr;
  assign bus_write = r_bus_write;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_cpuport_bus_master.sv
// Directed bench for cpuport_bus_master with a two-register responder model.
// Covers the CPUPORT_MASTER_TIMEOUT_EN build and the default build.
module tb_cpuport_bus_master;
  import cpuport_bus_master_pkg::*;

  localparam int ADDR_W = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              bus_cs;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_write;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;
  logic              bus_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpuport_bus_master #(
    .ADDR_W(ADDR_W), .READ_LATENCY(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bus_cs(bus_cs), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  // Responder: registered read data, one clock of latency.
  logic [7:0] r_mem [2];
  logic [7:0] last_wdata = 8'h00;
  int         n_writes = 0;

  always @(posedge clk) begin
    if (bus_cs && bus_ready) begin
      if (bus_write) begin
        r_mem[bus_addr] <= bus_wdata;
        last_wdata      <= bus_wdata;
        n_writes        <= n_writes + 1;
      end else begin
        bus_rdata <= r_mem[bus_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input op_e op, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    check("accept_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycle count is measured from the accept cycle; -1 means the budget ran out.
  task automatic wait_rsp(input int k0, input int budget, output int lat);
    int k;
    k = k0;
    while (!rsp_valid && k < budget) begin
      tick();
      k++;
    end
    lat = rsp_valid ? k : -1;
  endtask

  initial begin
    int lat;
    int w0;
    logic seen;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = 8'h00;
    bus_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_bus_cs", {31'd0, bus_cs}, 32'd0);
    check("rst_bus_addr", {31'd0, bus_addr}, 32'd0);
    check("rst_bus_write", {31'd0, bus_write}, 32'd0);
    check("rst_bus_wdata", {24'd0, bus_wdata}, 32'h00);
    reset = 1'b0;
    tick();

    // Plain write.
    w0 = n_writes;
    start_cmd(OP_WRITE, 1'b0, 8'h2F);
    check("wr_bus_cs", {31'd0, bus_cs}, 32'd1);
    check("wr_bus_write", {31'd0, bus_write}, 32'd1);
    check("wr_bus_addr", {31'd0, bus_addr}, 32'd0);
    check("wr_bus_wdata", {24'd0, bus_wdata}, 32'h2F);
    check("wr_busy", {31'd0, cmd_ready}, 32'd0);
    wait_rsp(1, 50, lat);
    check("wr_latency", lat, 32'd3);
    check("wr_rsp_data", {24'd0, rsp_data}, 32'h2F);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_count", n_writes, w0 + 1);
    check("wr_mem0", {24'd0, r_mem[0]}, 32'h2F);
    check("wr_ready_back", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("wr_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

    // Plain read.
    start_cmd(OP_WRITE, 1'b1, 8'h3F);
    wait_rsp(1, 50, lat);
    check("setup_latency", lat, 32'd3);
    w0 = n_writes;
    start_cmd(OP_READ, 1'b1, 8'h00);
    check("rd_bus_cs", {31'd0, bus_cs}, 32'd1);
    check("rd_bus_write", {31'd0, bus_write}, 32'd0);
    wait_rsp(1, 50, lat);
    check("rd_latency", lat, 32'd4);
    check("rd_rsp_data", {24'd0, rsp_data}, 32'h3F);
    check("rd_no_write", n_writes, w0);

    // Read-modify-write clear then set.
    start_cmd(OP_WRITE, 1'b1, 8'h37);
    wait_rsp(1, 50, lat);
    w0 = n_writes;
    start_cmd(OP_RMW_CLR, 1'b1, 8'h07);
    wait_rsp(1, 50, lat);
    check("clr_latency", lat, 32'd5);
    check("clr_rsp_old", {24'd0, rsp_data}, 32'h37);
    check("clr_wdata", {24'd0, last_wdata}, 32'h30);
    check("clr_one_write", n_writes, w0 + 1);
    start_cmd(OP_READ, 1'b1, 8'h00);
    wait_rsp(1, 50, lat);
    check("clr_readback", {24'd0, rsp_data}, 32'h30);
    start_cmd(OP_RMW_SET, 1'b1, 8'h08);
    wait_rsp(1, 50, lat);
    check("set_latency", lat, 32'd5);
    check("set_rsp_old", {24'd0, rsp_data}, 32'h30);
    check("set_wdata", {24'd0, last_wdata}, 32'h38);
    start_cmd(OP_READ, 1'b1, 8'h00);
    wait_rsp(1, 50, lat);
    check("set_readback", {24'd0, rsp_data}, 32'h38);

    // Five ready-low cycles during the write, plus a command offered while busy.
    w0 = n_writes;
    bus_ready = 1'b0;
    start_cmd(OP_WRITE, 1'b0, 8'h55);
    for (int i = 0; i < 5; i++) begin
      check("stall_stable", {bus_cs, bus_write, 7'd0, bus_addr, bus_wdata},
            {1'b1, 1'b1, 7'd0, 1'b0, 8'h55});
      if (i == 2) begin
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 1'b1;
        check("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("stall_no_write", n_writes, w0);
    bus_ready = 1'b1;
    wait_rsp(6, 50, lat);
    check("stall_latency", lat, 32'd8);
    check("stall_write_landed", {24'd0, r_mem[0]}, 32'h55);
    check("stall_one_write", n_writes, w0 + 1);
    tick();
    tick();
    check("busy_cmd_dropped", {31'd0, bus_cs}, 32'd0);

    // Reset while an RMW waits on read data.
    w0 = n_writes;
    start_cmd(OP_RMW_SET, 1'b0, 8'h01);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_bus_cs", {31'd0, bus_cs}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | rsp_valid | bus_cs;
      tick();
    end
    check("mid_rst_quiet", {31'd0, seen}, 32'd0);
    check("mid_rst_no_write", n_writes, w0);
    check("mid_rst_mem0", {24'd0, r_mem[0]}, 32'h55);

`ifdef CPUPORT_MASTER_TIMEOUT_EN
    // Eight stall cycles in the address phase abort the RMW.
    w0 = n_writes;
    bus_ready = 1'b0;
    start_cmd(OP_RMW_SET, 1'b1, 8'h40);
    wait_rsp(1, 50, lat);
    check("to_latency", lat, 32'd10);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("to_bus_cs", {31'd0, bus_cs}, 32'd0);
    check("to_no_write", n_writes, w0);
    bus_ready = 1'b1;
    tick();
    start_cmd(OP_READ, 1'b1, 8'h00);
    wait_rsp(1, 50, lat);
    check("to_recover_data", {24'd0, rsp_data}, 32'h38);
    check("to_recover_err", {31'd0, rsp_err}, 32'd0);
`else
    // Without the watchdog the master waits for as long as ready stays low.
    bus_ready = 1'b0;
    start_cmd(OP_RMW_SET, 1'b1, 8'h40);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    check("hang_no_rsp", {31'd0, seen}, 32'd0);
    check("hang_bus_cs", {31'd0, bus_cs}, 32'd1);
    check("hang_busy", {31'd0, cmd_ready}, 32'd0);
    bus_ready = 1'b1;
    wait_rsp(0, 50, lat);
    check("hang_resume_rsp", {31'd0, rsp_valid}, 32'd1);
    check("hang_rsp_old", {24'd0, rsp_data}, 32'h38);
    check("hang_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("hang_mem1", {24'd0, r_mem[1]}, 32'h78);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
